// File: rtl/noc_flit_rx_fifo_if.sv
// rtl/noc_flit_rx_fifo_if.sv - flit stream interface between injector, rx FIFO and router port
interface noc_flit_rx_fifo_if #(
    parameter int WIDTH = 20
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/noc_flit_rx_fifo.sv
// rtl/noc_flit_rx_fifo.sv - receive flit FIFO; optional NOC_FLIT_RX_ZERO_DROP_EN filters zero flits
module noc_flit_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    noc_flit_rx_fifo_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic [CNT_W-1:0]             rx_count,
    output logic [CNT_W-1:0]             drop_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push_req;
    logic             pop;
    logic             accept;
    logic             drop;

`ifdef NOC_FLIT_RX_ZERO_DROP_EN
    // All-zero words are idle fill from the injector and never enter the queue.
    assign push_req = bus.in_valid & (bus.in_data != '0);
`else
    assign push_req = bus.in_valid;
`endif

    // Status comes only from registered occupancy, never from the handshake inputs.
    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign bus.out_valid = ~empty;
    assign bus.out_data  = mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign pop    = bus.out_valid & bus.out_ready;
    assign accept = push_req & (~full | pop);
    assign drop   = push_req & full & ~pop;

    // Storage is not reset; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // Pointers, occupancy, sticky overflow and saturating statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                if (rx_count != '1) begin
                    rx_count <= rx_count + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (accept && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !accept) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_flit_rx_fifo.sv
// tb/tb_noc_flit_rx_fifo.sv - directed self-checking bench for noc_flit_rx_fifo
module tb_noc_flit_rx_fifo;
    logic        clk;
    logic        rst;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [15:0] rx_count;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

    logic [19:0] words [30];
    logic [19:0] q [$];

    noc_flit_rx_fifo_if #(.WIDTH(20)) bus ();

    noc_flit_rx_fifo #(.DEPTH(8), .WIDTH(20), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .rx_count   (rx_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int exp_rx, exp_drop, exp_ov, exp_cnt, first;
        logic do_pop, do_acc;

        words[0] = 20'h00000; words[1] = 20'h30010; words[2] = 20'h30020; words[3] = 20'h31011;
        words[4] = 20'h31021; words[5] = 20'h32012; words[6] = 20'h32022; words[7] = 20'h33423;
        for (int i = 8; i < 30; i++) words[i] = 20'h00000;

        // Reset state
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_rx_count", 32'(rx_count), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        rst = 1'b1;
        step();

        // Single flit, no same-cycle bypass
        bus.in_valid = 1'b1;
        bus.in_data = 20'h30010;
        bus.out_ready = 1'b1;
        #1;
        check("single_no_bypass", 32'(bus.out_valid), 0);
        step();
        bus.in_valid = 1'b0;
        check("single_valid", 32'(bus.out_valid), 1);
        check("single_data", 32'(bus.out_data), 32'h30010);
        check("single_count", 32'(count), 1);
        step();
        check("single_empty_after_pop", 32'(empty), 1);
        check("single_valid_after_pop", 32'(bus.out_valid), 0);
        check("single_rx_count", 32'(rx_count), 1);

        // Burst of 30 strobes with no consumer
        do_reset();
        for (int i = 0; i < 30; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = words[i];
            step();
        end
        bus.in_valid = 1'b0;
`ifdef NOC_FLIT_RX_ZERO_DROP_EN
        exp_rx = 7; exp_drop = 0; exp_ov = 0; exp_cnt = 7; first = 1;
`else
        exp_rx = 8; exp_drop = 22; exp_ov = 1; exp_cnt = 8; first = 0;
`endif
        check("burst_count", 32'(count), 32'(exp_cnt));
        check("burst_full", 32'(full), 32'(exp_cnt == 8));
        check("burst_rx_count", 32'(rx_count), 32'(exp_rx));
        check("burst_drop_count", 32'(drop_count), 32'(exp_drop));
        check("burst_overflow", 32'(overflow), 32'(exp_ov));
        bus.out_ready = 1'b1;
        for (int i = first; i < 8; i++) begin
            check($sformatf("burst_drain_valid_%0d", i), 32'(bus.out_valid), 1);
            check($sformatf("burst_drain_data_%0d", i), 32'(bus.out_data), 32'(words[i]));
            step();
        end
        check("burst_drained_empty", 32'(empty), 1);
        check("burst_overflow_sticky", 32'(overflow), 32'(exp_ov));

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 20'(32'h100 + i);
            step();
        end
        bus.in_valid = 1'b0;
        check("fill_full", 32'(full), 1);
        step();
        check("hold_data_stable", 32'(bus.out_data), 32'h100);
        check("hold_count", 32'(count), 8);
        bus.in_valid = 1'b1;
        bus.in_data = 20'h12345;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("pushpop_count", 32'(count), 8);
        check("pushpop_drop", 32'(drop_count), 0);
        check("pushpop_overflow", 32'(overflow), 0);
        check("pushpop_rx", 32'(rx_count), 9);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("pushpop_drain_%0d", i), 32'(bus.out_data), 32'h100 + i);
            step();
        end
        check("pushpop_last", 32'(bus.out_data), 32'h12345);
        step();
        check("pushpop_empty", 32'(empty), 1);

        // Wrap with random consumer, checked against a queue model
        do_reset();
        q.delete();
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 20'(32'h20000 + i);
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("wrap_valid_%0d", i), 32'(bus.out_valid), 32'(q.size() != 0));
            do_pop = bus.out_ready && (q.size() != 0);
            do_acc = (q.size() < 8) || do_pop;
            if (do_pop) begin
                check($sformatf("wrap_data_%0d", i), 32'(bus.out_data), 32'(q[0]));
                void'(q.pop_front());
            end
            if (do_acc) q.push_back(bus.in_data);
            step();
        end
        bus.in_valid = 1'b0;
        check("wrap_count", 32'(count), 32'(q.size()));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16 && q.size() != 0; i++) begin
            check($sformatf("wrap_drain_%0d", i), 32'(bus.out_data), 32'(q[0]));
            void'(q.pop_front());
            step();
        end
        check("wrap_drain_done", 32'(q.size()), 0);
        check("wrap_empty", 32'(empty), 1);

        // Asynchronous reset with five flits buffered
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 20'(32'h500 + i);
            step();
        end
        bus.in_valid = 1'b0;
        check("midrst_count_before", 32'(count), 5);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_count", 32'(count), 0);
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/noc_flit_rx_fifo.md
Name: noc_flit_rx_fifo

Overview:
- Receive-side buffer directly downstream of a per-node traffic injector (dataout buffer).
- Captures 20-bit flits presented with a single-cycle valid strobe. The injector has no backpressure input, so this block never stalls it.
- Holds flits in a circular FIFO and presents them to the router input port over a valid/ready handshake.
- Reports occupancy, overflow and received/dropped flit counts for debug and verification.

Parameters:
- DEPTH, 8, number of flit entries; any integer >= 2, not necessarily a power of two.
- WIDTH, 20, flit width in bits.
- CNT_W, 16, width of the received and dropped statistics counters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  flit from the injector.
- in_valid  input  1  in_data is valid this cycle; single-cycle strobe per flit.
- out_data  output  WIDTH  head-of-FIFO flit (first-word-fall-through).
- out_valid  output  1  FIFO non-empty; out_data is valid.
- out_ready  input  1  consumer accepts the head flit this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky flag; set when any flit is dropped because the FIFO is full.
- rx_count  output  CNT_W  flits accepted into the FIFO; saturating.
- drop_count  output  CNT_W  flits dropped on full; saturating.

Behaviour:
- Reset (rst low, asynchronous): rd_ptr=0, wr_ptr=0, count=0, overflow=0, rx_count=0, drop_count=0. Outputs after reset: out_valid=0, empty=1, full=0. Storage contents are don't-care.
- Reset asserted mid-operation discards all buffered flits immediately. No partial state survives.
- pop = out_valid & out_ready. push_req = in_valid (subject to the optional filter).
- Accept = push_req & (!full | pop): a slot freed by a pop in the same cycle is reusable.
- On accept: mem[wr_ptr] <= in_data; wr_ptr advances; rx_count increments and saturates at all-ones.
- Drop = push_req & full & !pop. On drop: the flit is discarded, overflow <= 1 (cleared only by reset), drop_count increments and saturates.
- Pop: rd_ptr advances. out_data = mem[rd_ptr] combinationally; out_valid = !empty.
- Pointers wrap from DEPTH-1 to 0 (modulo DEPTH, explicit compare, no power-of-two assumption).
- count update: +1 on accept without pop; -1 on pop without accept; unchanged on both or neither.
- Latency: a flit accepted at edge N is visible on out_data with out_valid=1 after edge N. There is no same-cycle bypass when empty.
- Pop while empty is impossible because out_valid=0; out_ready is ignored when empty.
- Ordering: strict FIFO. Flits are never reordered or duplicated.
- out_data holds stable while out_valid=1 and out_ready=0.
- full, empty and count are registered-state derived. They are glitch-free and not combinationally dependent on in_valid or out_ready.

Optional Feature:
- Macro: NOC_FLIT_RX_ZERO_DROP_EN.
- Defined: a flit with in_data == 0 is treated as an idle/filler word. push_req = in_valid & (in_data != 0). Zero flits are never stored and never counted in rx_count, drop_count or overflow.
- Not defined: every in_valid strobe is a push request, including all-zero words.

Test Plan:
- Reset: hold rst low 3 cycles -> out_valid=0, empty=1, full=0, count=0, overflow=0, rx_count=0, drop_count=0.
- Single flit: in_valid with 0x30010 at edge N, out_ready=1 -> out_valid=1, out_data=0x30010 after edge N; pop at edge N+1; empty=1 after it.
- Overflow, macro off: 30 consecutive strobes (words 0x00000, 0x30010, 0x30020, 0x31011, 0x31021, 0x32012, 0x32022, 0x33423, then 22 zeros), out_ready=0 -> count=8, full=1, rx_count=8, drop_count=22, overflow=1; draining yields the first 8 words in order.
- Same 30-word burst, macro on, out_ready=0 -> rx_count=7, drop_count=0, overflow=0, count=7; draining yields 0x30010..0x33423 in order.
- Full with simultaneous push and pop: fill to 8, then in_valid with 0x12345 and out_ready=1 in the same cycle -> flit accepted, count stays 8, no drop, 0x12345 emerges last.
- Wrap and mid-stream reset: 20 push/pop cycles with random out_ready -> output sequence equals input sequence across pointer wrap. Assert rst with count=5 -> count=0, out_valid=0 immediately.
